// File: rtl/output_psum_accumulator.sv
// output_psum_accumulator: accumulates per-channel partial sums across input tiles and emits packed, ReLU'd, saturated pixel words
module output_psum_accumulator #(
    parameter int Tm            = 8,
    parameter int FEATURE_WIDTH = 16,
    parameter int ACC_WIDTH     = 24,
    parameter int ADDR_WIDTH    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          config_enable,
    input  logic [7:0]                    num_in_tiles,
    input  logic [15:0]                   num_pixels,
    input  logic                          relu_en,
    input  logic [ADDR_WIDTH-1:0]         out_base_addr,
    input  logic                          feature_valid,
    input  logic [FEATURE_WIDTH-1:0]      feature_in,
    output logic                          feature_ready,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [Tm*FEATURE_WIDTH-1:0]   out_data,
    output logic [ADDR_WIDTH-1:0]         out_addr,
    output logic                          busy,
    output logic                          done
);
    localparam int CW = (Tm > 1) ? $clog2(Tm) : 1;
    localparam int FW = FEATURE_WIDTH;
    localparam int AW = ACC_WIDTH;

    typedef enum logic [1:0] {IDLE, ACCUM, STALL, DRAIN} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          ch_cnt_q, ch_cnt_d;
    logic [7:0]             tile_cnt_q, tile_cnt_d, tiles_q, tiles_d;
    logic [15:0]            pix_cnt_q, pix_cnt_d, comp_cnt_q, comp_cnt_d, pixels_q, pixels_d;
    logic                   relu_q, relu_d;
    logic signed [AW-1:0]   acc_q [Tm];
    logic signed [AW-1:0]   acc_d [Tm];
    logic                   out_valid_q, out_valid_d, done_q, done_d;
    logic [Tm*FW-1:0]       out_data_q, out_data_d, word_live, word_hold;
    logic [ADDR_WIDTH-1:0]  out_addr_q, out_addr_d;
    logic signed [AW-1:0]   new_sum;
    logic                   accept, out_accept, last_ch, last_tile, pix_done, last_pix;

    // clamp a one-bit-wider sum back into the accumulator range
    function automatic logic signed [AW-1:0] sat_acc(input logic signed [AW:0] s);
        return (s[AW] != s[AW-1]) ? {s[AW], {(AW-1){~s[AW]}}} : s[AW-1:0];
    endfunction

    // optional ReLU, then clamp to the feature range
    function automatic logic [FW-1:0] fin(input logic signed [AW-1:0] a, input logic relu);
        logic signed [AW-1:0] r;
        r = (relu && a[AW-1]) ? '0 : a;
        return (&r[AW-1:FW-1] || ~|r[AW-1:FW-1]) ? r[FW-1:0] : {r[AW-1], {(FW-1){~r[AW-1]}}};
    endfunction

    assign feature_ready = (state_q == ACCUM);
    assign busy          = (state_q != IDLE);
    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign out_addr      = out_addr_q;
    assign done          = done_q;
    assign accept        = feature_valid && feature_ready;
    assign out_accept    = out_valid_q && out_ready;
    assign last_ch       = (ch_cnt_q == CW'(Tm - 1));
    assign last_tile     = (tile_cnt_q == tiles_q - 8'd1);
    assign pix_done      = accept && last_ch && last_tile;
    assign last_pix      = (comp_cnt_q == pixels_q - 16'd1);

    // running sum for the current channel; first tile of a pixel starts fresh
    always_comb begin
        new_sum = sat_acc(((tile_cnt_q == 8'd0) ? '0 : {acc_q[ch_cnt_q][AW-1], acc_q[ch_cnt_q]})
                          + {{(AW-FW+1){feature_in[FW-1]}}, feature_in});
    end

    // finished words: live includes the sum being accepted now, hold reads only stored sums
    always_comb begin
        word_live = '0;
        word_hold = '0;
        for (int k = 0; k < Tm; k++) begin
            word_hold[k*FW +: FW] = fin(acc_q[k], relu_q);
            word_live[k*FW +: FW] = fin((k == Tm - 1) ? new_sum : acc_q[k], relu_q);
        end
    end

    // next-state logic for the control FSM, counters, accumulators and output register
    always_comb begin
        state_d     = state_q;
        ch_cnt_d    = ch_cnt_q;
        tile_cnt_d  = tile_cnt_q;
        tiles_d     = tiles_q;
        pixels_d    = pixels_q;
        relu_d      = relu_q;
        comp_cnt_d  = comp_cnt_q;
        acc_d       = acc_q;
        done_d      = 1'b0;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q && !out_ready;
        out_addr_d  = out_accept ? out_addr_q + ADDR_WIDTH'(1) : out_addr_q;
        pix_cnt_d   = pix_cnt_q + 16'(out_accept);
        case (state_q)
            IDLE: if (config_enable) begin
                tiles_d    = (num_in_tiles == 8'd0) ? 8'd1 : num_in_tiles;
                pixels_d   = num_pixels;
                relu_d     = relu_en;
                out_addr_d = out_base_addr;
                ch_cnt_d   = '0;
                tile_cnt_d = '0;
                pix_cnt_d  = '0;
                comp_cnt_d = '0;
                for (int k = 0; k < Tm; k++) acc_d[k] = '0;
                done_d     = (num_pixels == 16'd0);
                state_d    = (num_pixels == 16'd0) ? IDLE : ACCUM;
            end
            ACCUM: if (accept) begin
                acc_d[ch_cnt_q] = new_sum;
                ch_cnt_d        = last_ch ? '0 : ch_cnt_q + CW'(1);
                tile_cnt_d      = !last_ch ? tile_cnt_q : last_tile ? 8'd0 : tile_cnt_q + 8'd1;
                if (pix_done) begin
                    comp_cnt_d = comp_cnt_q + 16'd1;
                    if (!out_valid_q || out_ready) begin
                        out_valid_d = 1'b1;
                        out_data_d  = word_live;
                        state_d     = last_pix ? DRAIN : ACCUM;
                    end else begin
                        state_d = STALL;
                    end
                end
            end
            STALL: if (out_ready) begin
                out_valid_d = 1'b1;
                out_data_d  = word_hold;
                state_d     = (comp_cnt_q == pixels_q) ? DRAIN : ACCUM;
            end
            DRAIN: if (out_accept) begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // state registers with asynchronous clear of everything, including any pending word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ch_cnt_q    <= '0;
            tile_cnt_q  <= '0;
            tiles_q     <= 8'd1;
            pixels_q    <= '0;
            relu_q      <= 1'b0;
            pix_cnt_q   <= '0;
            comp_cnt_q  <= '0;
            for (int k = 0; k < Tm; k++) acc_q[k] <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_cnt_q    <= ch_cnt_d;
            tile_cnt_q  <= tile_cnt_d;
            tiles_q     <= tiles_d;
            pixels_q    <= pixels_d;
            relu_q      <= relu_d;
            pix_cnt_q   <= pix_cnt_d;
            comp_cnt_q  <= comp_cnt_d;
            for (int k = 0; k < Tm; k++) acc_q[k] <= acc_d[k];
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            done_q      <= done_d;
        end
    end
endmodule

// File: tb/tb_output_psum_accumulator.sv
// tb_output_psum_accumulator: directed tests of the output partial-sum accumulator
module tb_output_psum_accumulator;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         config_enable = 1'b0;
    logic [7:0]   num_in_tiles = '0;
    logic [15:0]  num_pixels = '0;
    logic         relu_en = 1'b0;
    logic [15:0]  out_base_addr = '0;
    logic         feature_valid = 1'b0;
    logic [15:0]  feature_in = '0;
    logic         feature_ready;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] out_data;
    logic [15:0]  out_addr;
    logic         busy;
    logic         done;

    int total = 0;
    int passed = 0;

    logic [127:0] q_data[$];
    logic [15:0]  q_addr[$];
    int cyc = 0, done_cnt = 0, done_cyc = -1, acc_cyc = -1;

    output_psum_accumulator dut (
        .clk(clk), .rst(rst), .config_enable(config_enable), .num_in_tiles(num_in_tiles),
        .num_pixels(num_pixels), .relu_en(relu_en), .out_base_addr(out_base_addr),
        .feature_valid(feature_valid), .feature_in(feature_in), .feature_ready(feature_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // output-side monitor, sampled mid-cycle
    always @(negedge clk) begin
        cyc++;
        if (out_valid && out_ready) begin
            q_data.push_back(out_data);
            q_addr.push_back(out_addr);
            acc_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    function automatic logic [127:0] ramp(input int start);
        logic [127:0] w;
        w = '0;
        for (int k = 0; k < 8; k++) w[k*16 +: 16] = 16'(start + k);
        return w;
    endfunction

    task automatic clear_mon();
        q_data.delete();
        q_addr.delete();
        done_cnt = 0;
        done_cyc = -1;
        acc_cyc = -1;
    endtask

    task automatic cfg(input logic [7:0] t, input logic [15:0] p, input logic r, input logic [15:0] b);
        num_in_tiles = t;
        num_pixels = p;
        relu_en = r;
        out_base_addr = b;
        config_enable = 1'b1;
        @(posedge clk); #1;
        config_enable = 1'b0;
    endtask

    task automatic feed(input logic [15:0] v);
        int n;
        n = 0;
        feature_valid = 1'b1;
        feature_in = v;
        while (!feature_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) begin
            total++;
            $display("FAIL feed_timeout: feature_ready stayed 0 for %0d cycles, required 1", n);
        end
        @(posedge clk); #1;
        feature_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) begin
            total++;
            $display("FAIL idle_timeout: busy stayed 1 for %0d cycles, required 0", n);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else passed++;
        total++; if (out_data !== '0) $display("FAIL rst_out_data: got %h want 0", out_data); else passed++;
        total++; if (out_addr !== '0) $display("FAIL rst_out_addr: got %h want 0", out_addr); else passed++;
        total++; if (feature_ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", feature_ready); else passed++;
        total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL rst_busy_done: got %b%b want 00", busy, done); else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        clear_mon();
        out_ready = 1'b1;
        cfg(8'd1, 16'd2, 1'b0, 16'h0100);
        total++; if (busy !== 1'b1 || feature_ready !== 1'b1) $display("FAIL basic_start: busy/ready got %b%b want 11", busy, feature_ready); else passed++;
        for (int i = 1; i <= 8; i++) feed(16'(i));
        total++; if (out_valid !== 1'b1 || out_data !== ramp(1)) $display("FAIL basic_latency: valid %b data %h want 1 %h", out_valid, out_data, ramp(1)); else passed++;
        for (int i = 9; i <= 16; i++) feed(16'(i));
        wait_idle();
        total++; if (q_data.size() !== 2) $display("FAIL basic_count: got %0d words want 2", q_data.size()); else passed++;
        if (q_data.size() == 2) begin
            total++; if (q_data[0] !== ramp(1) || q_addr[0] !== 16'h0100) $display("FAIL basic_word0: got %h@%h want %h@0100", q_data[0], q_addr[0], ramp(1)); else passed++;
            total++; if (q_data[1] !== ramp(9) || q_addr[1] !== 16'h0101) $display("FAIL basic_word1: got %h@%h want %h@0101", q_data[1], q_addr[1], ramp(9)); else passed++;
        end
        total++; if (done_cnt !== 1 || done_cyc !== acc_cyc + 1) $display("FAIL basic_done: pulses %0d at %0d want 1 at %0d", done_cnt, done_cyc, acc_cyc + 1); else passed++;
    endtask

    task automatic test_tiles();
        clear_mon();
        cfg(8'd3, 16'd1, 1'b0, 16'h0010);
        for (int i = 0; i < 24; i++) feed(16'd100);
        wait_idle();
        total++; if (q_data.size() !== 1) $display("FAIL tiles_count: got %0d words want 1", q_data.size()); else passed++;
        if (q_data.size() == 1) begin
            total++; if (q_data[0] !== {8{16'd300}} || q_addr[0] !== 16'h0010) $display("FAIL tiles_word: got %h@%h want %h@0010", q_data[0], q_addr[0], {8{16'd300}}); else passed++;
        end
    endtask

    task automatic run_relu(input logic r, input logic [127:0] exp, input string nm);
        logic [15:0] t0 [8];
        t0 = '{16'hFFFD, 16'h7FFF, 16'h8000, 16'd0, 16'd0, 16'd0, 16'd0, 16'd4};
        clear_mon();
        cfg(8'd2, 16'd1, r, 16'h0020);
        for (int i = 0; i < 8; i++) feed(t0[i]);
        for (int i = 0; i < 8; i++) feed(i == 0 ? 16'hFFFE : t0[i]);
        wait_idle();
        total++; if (q_data.size() !== 1 || q_data[0] !== exp) $display("FAIL %s: got %0d words, %h want %h", nm, q_data.size(), q_data.size() ? q_data[0] : '0, exp); else passed++;
    endtask

    task automatic test_relu();
        run_relu(1'b1, {16'd8, 64'd0, 16'h0000, 16'h7FFF, 16'h0000}, "relu_on");
        run_relu(1'b0, {16'd8, 64'd0, 16'h8000, 16'h7FFF, 16'hFFFB}, "relu_off");
    endtask

    task automatic test_back_to_back();
        int bad;
        bad = 0;
        clear_mon();
        out_ready = 1'b0;
        cfg(8'd1, 16'd2, 1'b0, 16'h0200);
        for (int i = 1; i <= 8; i++) feed(16'(i));
        for (int i = 9; i <= 16; i++) begin
            feed(16'(i));
            if (out_valid !== 1'b1 || out_data !== ramp(1) || out_addr !== 16'h0200) bad++;
        end
        total++; if (feature_ready !== 1'b0) $display("FAIL stall_ready: got %b want 0", feature_ready); else passed++;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || out_data !== ramp(1) || out_addr !== 16'h0200) bad++;
        end
        total++; if (bad !== 0) $display("FAIL stall_hold: %0d unstable cycles want 0", bad); else passed++;
        out_ready = 1'b1;
        wait_idle();
        total++; if (q_data.size() !== 2) $display("FAIL stall_count: got %0d words want 2", q_data.size()); else passed++;
        if (q_data.size() == 2) begin
            total++; if (q_data[0] !== ramp(1) || q_addr[0] !== 16'h0200) $display("FAIL stall_word0: got %h@%h want %h@0200", q_data[0], q_addr[0], ramp(1)); else passed++;
            total++; if (q_data[1] !== ramp(9) || q_addr[1] !== 16'h0201) $display("FAIL stall_word1: got %h@%h want %h@0201", q_data[1], q_addr[1], ramp(9)); else passed++;
        end
        total++; if (done_cnt !== 1) $display("FAIL stall_done: got %0d pulses want 1", done_cnt); else passed++;
    endtask

    task automatic test_reset_mid();
        clear_mon();
        out_ready = 1'b0;
        cfg(8'd1, 16'd3, 1'b0, 16'h0300);
        for (int i = 0; i < 8; i++) feed(16'd50);
        for (int i = 0; i < 3; i++) feed(16'd77);
        total++; if (out_valid !== 1'b1) $display("FAIL mid_pre_valid: got %b want 1", out_valid); else passed++;
        rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0 || out_data !== '0 || out_addr !== '0) $display("FAIL mid_async: valid %b data %h addr %h want all 0", out_valid, out_data, out_addr); else passed++;
        total++; if (feature_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) $display("FAIL mid_async_ctl: ready/busy/done %b%b%b want 000", feature_ready, busy, done); else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        clear_mon();
        cfg(8'd2, 16'd1, 1'b0, 16'h0400);
        for (int t = 0; t < 2; t++)
            for (int i = 1; i <= 8; i++) feed(16'(i));
        wait_idle();
        total++; if (q_data.size() !== 1 || q_data[0] !== {16'd16, 16'd14, 16'd12, 16'd10, 16'd8, 16'd6, 16'd4, 16'd2} || q_addr[0] !== 16'h0400)
            $display("FAIL mid_restart: got %0d words, %h@%h want 1 word @0400", q_data.size(), q_data.size() ? q_data[0] : '0, q_addr.size() ? q_addr[0] : '0); else passed++;
    endtask

    task automatic test_zero_pixels();
        clear_mon();
        cfg(8'd1, 16'd0, 1'b0, 16'h0700);
        total++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL zero_done: done/busy %b%b want 10", done, busy); else passed++;
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++; if (q_data.size() !== 0 || done_cnt !== 1) $display("FAIL zero_words: %0d words %0d pulses want 0 and 1", q_data.size(), done_cnt); else passed++;
    endtask

    task automatic test_cfg_ignored();
        clear_mon();
        cfg(8'd1, 16'd1, 1'b0, 16'h0500);
        for (int i = 1; i <= 3; i++) feed(16'(i));
        cfg(8'd2, 16'd5, 1'b1, 16'h0600);
        for (int i = 4; i <= 8; i++) feed(16'(i));
        wait_idle();
        total++; if (q_data.size() !== 1 || q_data[0] !== ramp(1) || q_addr[0] !== 16'h0500) $display("FAIL cfg_ignored: got %0d words, %h@%h want %h@0500", q_data.size(), q_data.size() ? q_data[0] : '0, q_addr.size() ? q_addr[0] : '0, ramp(1)); else passed++;
        total++; if (done_cnt !== 1 || busy !== 1'b0) $display("FAIL cfg_ignored_done: pulses %0d busy %b want 1 0", done_cnt, busy); else passed++;
    endtask

    task automatic test_addr_wrap();
        clear_mon();
        cfg(8'd0, 16'd2, 1'b0, 16'hFFFF);
        for (int i = 0; i < 16; i++) feed(16'd1);
        wait_idle();
        total++; if (q_addr.size() !== 2 || q_addr[0] !== 16'hFFFF || q_addr[1] !== 16'h0000) $display("FAIL addr_wrap: got %0d words addrs %h %h want FFFF 0000", q_addr.size(), q_addr.size() > 0 ? q_addr[0] : '0, q_addr.size() > 1 ? q_addr[1] : '0); else passed++;
        total++; if (q_data.size() == 2 && q_data[1] !== {8{16'd1}}) $display("FAIL wrap_data: got %h want %h", q_data[1], {8{16'd1}}); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tiles();
        test_relu();
        test_back_to_back();
        test_reset_mid();
        test_zero_pixels();
        test_cfg_ignored();
        test_addr_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
